// File: rtl/slink_ph_assembler_pkg.sv
// rtl/slink_ph_assembler_pkg.sv - S-Link packet header shared types and constants
// FSM encodings, byte positions and the 24-bit header ECC column table.
package slink_ph_assembler_pkg;

   localparam int PH_WIDTH  = 24;
   localparam int ECC_WIDTH = 6;

   localparam logic [1:0] POS_BYTE0 = 2'd0;
   localparam logic [1:0] POS_BYTE1 = 2'd1;
   localparam logic [1:0] POS_BYTE2 = 2'd2;
   localparam logic [1:0] POS_ECC   = 2'd3;

   typedef enum logic [1:0] {
      ST_B0  = POS_BYTE0,
      ST_B1  = POS_BYTE1,
      ST_B2  = POS_BYTE2,
      ST_ECC = POS_ECC
   } ph_state_e;

   // Parity bits P5..P0 touched by header bit idx; every column is unique and weight >= 3.
   function automatic logic [ECC_WIDTH-1:0] ecc_column(input logic [4:0] idx);
      logic [ECC_WIDTH-1:0] col;
      case (idx)
         5'd0:    col = 6'h07;
         5'd1:    col = 6'h0B;
         5'd2:    col = 6'h0D;
         5'd3:    col = 6'h0E;
         5'd4:    col = 6'h13;
         5'd5:    col = 6'h15;
         5'd6:    col = 6'h16;
         5'd7:    col = 6'h19;
         5'd8:    col = 6'h1A;
         5'd9:    col = 6'h1C;
         5'd10:   col = 6'h23;
         5'd11:   col = 6'h25;
         5'd12:   col = 6'h26;
         5'd13:   col = 6'h29;
         5'd14:   col = 6'h2A;
         5'd15:   col = 6'h2C;
         5'd16:   col = 6'h31;
         5'd17:   col = 6'h32;
         5'd18:   col = 6'h34;
         5'd19:   col = 6'h38;
         5'd20:   col = 6'h1F;
         5'd21:   col = 6'h2F;
         5'd22:   col = 6'h37;
         5'd23:   col = 6'h3B;
         default: col = 6'h00;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/slink_ph_assembler_if.sv
// rtl/slink_ph_assembler_if.sv - byte input stream and header output stream bundle
interface slink_ph_assembler_if;
   logic        byte_valid;
   logic        byte_sop;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        ph_valid;
   logic        ph_ready;
   logic [23:0] ph_data;
   logic        ph_corrected;
   logic        ph_corrupt;

   modport master (
      output byte_valid, byte_sop, byte_data, ph_ready,
      input  byte_ready, ph_valid, ph_data, ph_corrected, ph_corrupt
   );

   modport slave (
      input  byte_valid, byte_sop, byte_data, ph_ready,
      output byte_ready, ph_valid, ph_data, ph_corrected, ph_corrupt
   );
endinterface

// File: rtl/slink_ecc_syndrome.sv
// rtl/slink_ecc_syndrome.sv - header ECC syndrome check and single-bit correction
module slink_ecc_syndrome
   import slink_ph_assembler_pkg::*;
(
   input  logic [PH_WIDTH-1:0]  hdr_i,
   input  logic [ECC_WIDTH-1:0] ecc_i,
   output logic [PH_WIDTH-1:0]  hdr_o,
   output logic                 corrected_o,
   output logic                 corrupt_o
);

   logic [ECC_WIDTH-1:0] calc;
   logic [ECC_WIDTH-1:0] syndrome;
   logic                 hit;

   always_comb begin
      calc = '0;
      for (int i = 0; i < PH_WIDTH; i++) begin
         if (hdr_i[i]) calc = calc ^ ecc_column(5'(i));
      end
      syndrome = calc ^ ecc_i;

      hdr_o       = hdr_i;
      corrected_o = 1'b0;
      corrupt_o   = 1'b0;
      hit         = 1'b0;
      // A one-hot syndrome points at a flipped ECC bit; the header itself is intact.
      if (syndrome != '0) begin
         if ($onehot(syndrome)) begin
            corrected_o = 1'b1;
         end else begin
            for (int i = 0; i < PH_WIDTH; i++) begin
               if (ecc_column(5'(i)) == syndrome) begin
                  hdr_o[i] = ~hdr_i[i];
                  hit      = 1'b1;
               end
            end
            corrected_o = hit;
            corrupt_o   = ~hit;
         end
      end
   end

endmodule

// File: rtl/slink_ph_assembler.sv
// rtl/slink_ph_assembler.sv - assembles 3 header bytes + ECC into a checked packet header
module slink_ph_assembler
   import slink_ph_assembler_pkg::*;
#(
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   slink_ph_assembler_if.slave      ph_if,
   output logic                     sync_err,
   input  logic                     cnt_clear,
   output logic [ERR_CNT_WIDTH-1:0] corrected_cnt,
   output logic [ERR_CNT_WIDTH-1:0] corrupt_cnt
);

   ph_state_e                state_q;
   logic [2:0][7:0]          hdr_q;
   logic                     ph_valid_q;
   logic [PH_WIDTH-1:0]      ph_data_q;
   logic                     ph_corrected_q;
   logic                     ph_corrupt_q;
   logic                     sync_err_q;
   logic [ERR_CNT_WIDTH-1:0] corrected_cnt_q, corrected_cnt_d;
   logic [ERR_CNT_WIDTH-1:0] corrupt_cnt_q, corrupt_cnt_d;

   logic                byte_ready;
   logic                accept;
   logic                ph_load;
   logic [PH_WIDTH-1:0] fixed_hdr;
   logic                fix_corrected;
   logic                fix_corrupt;

   // Only the ECC byte can stall, and only while the output slot is still occupied.
   assign byte_ready = !((state_q == ST_ECC) && ph_valid_q && !ph_if.ph_ready);
   assign accept     = ph_if.byte_valid && byte_ready;
   assign ph_load    = accept && (state_q == ST_ECC) && !ph_if.byte_sop;

   slink_ecc_syndrome u_ecc (
      .hdr_i       ({hdr_q[POS_BYTE2], hdr_q[POS_BYTE1], hdr_q[POS_BYTE0]}),
      .ecc_i       (ph_if.byte_data[ECC_WIDTH-1:0]),
      .hdr_o       (fixed_hdr),
      .corrected_o (fix_corrected),
      .corrupt_o   (fix_corrupt)
   );

   always_comb begin
      corrected_cnt_d = corrected_cnt_q;
      corrupt_cnt_d   = corrupt_cnt_q;
      if (cnt_clear) begin
         corrected_cnt_d = '0;
         corrupt_cnt_d   = '0;
      end else if (ph_load) begin
         if (fix_corrected && (corrected_cnt_q != '1)) corrected_cnt_d = corrected_cnt_q + 1'b1;
         if (fix_corrupt && (corrupt_cnt_q != '1))     corrupt_cnt_d   = corrupt_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_B0;
         hdr_q           <= '0;
         ph_valid_q      <= 1'b0;
         ph_data_q       <= '0;
         ph_corrected_q  <= 1'b0;
         ph_corrupt_q    <= 1'b0;
         sync_err_q      <= 1'b0;
         corrected_cnt_q <= '0;
         corrupt_cnt_q   <= '0;
      end else begin
         sync_err_q      <= 1'b0;
         corrected_cnt_q <= corrected_cnt_d;
         corrupt_cnt_q   <= corrupt_cnt_d;

         if (accept) begin
            if (ph_if.byte_sop) begin
               hdr_q[POS_BYTE0] <= ph_if.byte_data;
               state_q          <= ST_B1;
               sync_err_q       <= (state_q != ST_B0);
            end else begin
               case (state_q)
                  ST_B1: begin
                     hdr_q[POS_BYTE1] <= ph_if.byte_data;
                     state_q          <= ST_B2;
                  end
                  ST_B2: begin
                     hdr_q[POS_BYTE2] <= ph_if.byte_data;
                     state_q          <= ST_ECC;
                  end
                  ST_ECC:  state_q <= ST_B0;
                  default: state_q <= ST_B0;
               endcase
            end
         end

         if (ph_load) begin
            ph_valid_q     <= 1'b1;
            ph_data_q      <= fixed_hdr;
            ph_corrected_q <= fix_corrected;
            ph_corrupt_q   <= fix_corrupt;
         end else if (ph_if.ph_ready) begin
            ph_valid_q     <= 1'b0;
         end
      end
   end

   assign ph_if.byte_ready   = byte_ready;
   assign ph_if.ph_valid     = ph_valid_q;
   assign ph_if.ph_data      = ph_data_q;
   assign ph_if.ph_corrected = ph_corrected_q;
   assign ph_if.ph_corrupt   = ph_corrupt_q;
   assign sync_err           = sync_err_q;
   assign corrected_cnt      = corrected_cnt_q;
   assign corrupt_cnt        = corrupt_cnt_q;

endmodule

// File: tb/tb_slink_ph_assembler.sv
// tb/tb_slink_ph_assembler.sv - directed bench for slink_ph_assembler
module tb_slink_ph_assembler;

   logic        clk = 1'b0;
   logic        reset;
   logic        cnt_clear;
   logic        sync_err, sync_err2;
   logic [15:0] corrected_cnt, corrupt_cnt;
   logic [1:0]  corrected_cnt2, corrupt_cnt2;
   int          checks = 0;
   int          errors = 0;
   int          hs_cnt = 0;
   int          hs_ref;

   slink_ph_assembler_if bif ();
   slink_ph_assembler_if bif2 ();

   assign bif2.byte_valid = bif.byte_valid;
   assign bif2.byte_sop   = bif.byte_sop;
   assign bif2.byte_data  = bif.byte_data;
   assign bif2.ph_ready   = bif.ph_ready;

   slink_ph_assembler #(.ERR_CNT_WIDTH(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .ph_if         (bif),
      .sync_err      (sync_err),
      .cnt_clear     (cnt_clear),
      .corrected_cnt (corrected_cnt),
      .corrupt_cnt   (corrupt_cnt)
   );

   slink_ph_assembler #(.ERR_CNT_WIDTH(2)) dut2 (
      .clk           (clk),
      .reset         (reset),
      .ph_if         (bif2),
      .sync_err      (sync_err2),
      .cnt_clear     (cnt_clear),
      .corrected_cnt (corrected_cnt2),
      .corrupt_cnt   (corrupt_cnt2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bif.ph_valid && bif.ph_ready) hs_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic sop);
      int n;
      n = 0;
      bif.byte_valid = 1'b1;
      bif.byte_sop   = sop;
      bif.byte_data  = d;
      @(negedge clk);
      while (!bif.byte_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!bif.byte_ready) begin
         checks++;
         errors++;
         $error("FAIL send_timeout observed=byte_ready_low expected=accept data=%0h", d);
      end
      @(posedge clk);
      #1;
      bif.byte_valid = 1'b0;
      bif.byte_sop   = 1'b0;
   endtask

   task automatic send_hdr(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] ecc);
      send_byte(b0, 1'b1);
      send_byte(b1, 1'b0);
      send_byte(b2, 1'b0);
      send_byte(ecc, 1'b0);
   endtask

   initial begin
      reset          = 1'b1;
      cnt_clear      = 1'b0;
      bif.byte_valid = 1'b0;
      bif.byte_sop   = 1'b0;
      bif.byte_data  = 8'h00;
      bif.ph_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ph_valid", 32'(bif.ph_valid), 32'h0);
      check("rst_ph_data", 32'(bif.ph_data), 32'h0);
      check("rst_flags", {30'h0, bif.ph_corrected, bif.ph_corrupt}, 32'h0);
      check("rst_sync_err", 32'(sync_err), 32'h0);
      check("rst_cnts", {corrected_cnt, corrupt_cnt}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_byte_ready", 32'(bif.byte_ready), 32'h1);

      send_hdr(8'h01, 8'h00, 8'h00, 8'h07);
      check("clean_valid", 32'(bif.ph_valid), 32'h1);
      check("clean_data", 32'(bif.ph_data), 32'h000001);
      check("clean_flags", {30'h0, bif.ph_corrected, bif.ph_corrupt}, 32'h0);

      send_hdr(8'h00, 8'h00, 8'h00, 8'h07);
      check("fix_d0_data", 32'(bif.ph_data), 32'h000001);
      check("fix_d0_flag", 32'(bif.ph_corrected), 32'h1);
      check("fix_d0_cnt", 32'(corrected_cnt), 32'h1);

      send_hdr(8'h00, 8'h00, 8'h00, 8'h03);
      check("corrupt_data", 32'(bif.ph_data), 32'h000000);
      check("corrupt_flags", {30'h0, bif.ph_corrected, bif.ph_corrupt}, 32'h1);
      check("corrupt_cnt", 32'(corrupt_cnt), 32'h1);
      check("corrupt_cnt_w2", 32'(corrupt_cnt2), 32'h1);

      send_hdr(8'h00, 8'h00, 8'h00, 8'h01);
      check("eccbit_data", 32'(bif.ph_data), 32'h000000);
      check("eccbit_flags", {30'h0, bif.ph_corrected, bif.ph_corrupt}, 32'h2);
      check("eccbit_cnt", 32'(corrected_cnt), 32'h2);

      send_hdr(8'h01, 8'h00, 8'h00, 8'hC7);
      check("ecc76_data", 32'(bif.ph_data), 32'h000001);
      check("ecc76_flags", {30'h0, bif.ph_corrected, bif.ph_corrupt}, 32'h0);

      send_hdr(8'h00, 8'h00, 8'h00, 8'h3B);
      check("fix_d23_data", 32'(bif.ph_data), 32'h800000);
      check("fix_d23_cnt", 32'(corrected_cnt), 32'h3);

      @(posedge clk);
      #1;
      hs_ref = hs_cnt;
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b0);
      check("sync_quiet", 32'(sync_err), 32'h0);
      send_byte(8'h01, 1'b1);
      check("sync_pulse", 32'(sync_err), 32'h1);
      send_byte(8'h00, 1'b0);
      check("sync_one_cycle", 32'(sync_err), 32'h0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h07, 1'b0);
      check("sync_hdr_data", 32'(bif.ph_data), 32'h000001);
      check("sync_hdr_flags", {30'h0, bif.ph_corrected, bif.ph_corrupt}, 32'h0);
      @(posedge clk);
      #1;
      check("sync_single_hdr", hs_cnt - hs_ref, 32'h1);

      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      send_hdr(8'h02, 8'h00, 8'h00, 8'h0B);
      check("drop_b0_data", 32'(bif.ph_data), 32'h000002);
      check("drop_b0_sync", 32'(sync_err), 32'h0);

      @(posedge clk);
      #1;
      hs_ref       = hs_cnt;
      bif.ph_ready = 1'b0;
      send_hdr(8'h02, 8'h00, 8'h00, 8'h0B);
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      bif.byte_valid = 1'b1;
      bif.byte_data  = 8'h0C;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_byte_ready", 32'(bif.byte_ready), 32'h0);
      end
      check("bp_hold_valid", 32'(bif.ph_valid), 32'h1);
      check("bp_hold_data", 32'(bif.ph_data), 32'h000002);
      bif.ph_ready = 1'b1;
      @(posedge clk);
      #1;
      bif.byte_valid = 1'b0;
      check("b2b_valid", 32'(bif.ph_valid), 32'h1);
      check("b2b_data", 32'(bif.ph_data), 32'h000003);
      check("b2b_hs_first", hs_cnt - hs_ref, 32'h1);
      @(posedge clk);
      #1;
      check("b2b_drained", 32'(bif.ph_valid), 32'h0);
      check("b2b_hs_both", hs_cnt - hs_ref, 32'h2);

      @(negedge clk);
      cnt_clear = 1'b1;
      @(posedge clk);
      #1;
      cnt_clear = 1'b0;
      check("clr_cnts", {corrected_cnt, corrupt_cnt}, 32'h0);
      check("clr_cnts_w2", {28'h0, corrected_cnt2, corrupt_cnt2}, 32'h0);
      repeat (5) send_hdr(8'h00, 8'h00, 8'h00, 8'h07);
      check("sat_cnt_w16", 32'(corrected_cnt), 32'h5);
      check("sat_cnt_w2", 32'(corrected_cnt2), 32'h3);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      cnt_clear = 1'b1;
      send_byte(8'h07, 1'b0);
      cnt_clear = 1'b0;
      check("clr_prio_flag", 32'(bif.ph_corrected), 32'h1);
      check("clr_prio_w16", 32'(corrected_cnt), 32'h0);
      check("clr_prio_w2", 32'(corrected_cnt2), 32'h0);

      send_hdr(8'h00, 8'h00, 8'h00, 8'h03);
      check("pre_rst_corrupt", 32'(corrupt_cnt), 32'h1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b0);
      reset = 1'b1;
      #2;
      check("mid_rst_valid", 32'(bif.ph_valid), 32'h0);
      check("mid_rst_cnt", 32'(corrupt_cnt), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      hs_ref = hs_cnt;
      send_byte(8'h00, 1'b0);
      check("mid_rst_no_sync", 32'(sync_err), 32'h0);
      send_byte(8'h07, 1'b0);
      @(posedge clk);
      #1;
      check("mid_rst_discard", hs_cnt - hs_ref, 32'h0);
      check("mid_rst_idle", 32'(bif.ph_valid), 32'h0);
      send_hdr(8'h02, 8'h00, 8'h00, 8'h0B);
      check("post_rst_data", 32'(bif.ph_data), 32'h000002);
      check("post_rst_valid", 32'(bif.ph_valid), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
